// File: rtl/det_pkg.sv
// Shared definitions for the 5x5 determinant controller and its datapath.
package det_pkg;

  localparam int N      = 5;
  localparam int ELEM_W = 8;
  localparam int MAT_W  = N * N * ELEM_W;
  localparam int DET_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic signed [ELEM_W-1:0] elem_t;
  typedef logic signed [DET_W-1:0]  det_t;

endpackage

// File: rtl/determinante_5x5.sv
// Purely combinational 5x5 determinant by cofactor expansion along row 0.
// All arithmetic is 32-bit two's complement and wraps silently on overflow.
module determinante_5x5
  import det_pkg::*;
(
  input  logic [MAT_W-1:0]        matriz_5x5,
  output logic signed [DET_W-1:0] det
);

  function automatic det_t det3(input det_t m [3][3]);
    return m[0][0] * (m[1][1] * m[2][2] - m[1][2] * m[2][1])
         - m[0][1] * (m[1][0] * m[2][2] - m[1][2] * m[2][0])
         + m[0][2] * (m[1][0] * m[2][1] - m[1][1] * m[2][0]);
  endfunction

  function automatic det_t det4(input det_t m [4][4]);
    det_t acc;
    det_t sub [3][3];
    acc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 1; r < 4; r++) begin
        for (int k = 0; k < 3; k++) begin
          sub[r-1][k] = m[r][(k < c) ? k : k + 1];
        end
      end
      if (c % 2 == 0) acc = acc + m[0][c] * det3(sub);
      else            acc = acc - m[0][c] * det3(sub);
    end
    return acc;
  endfunction

  function automatic det_t det5(input det_t m [5][5]);
    det_t acc;
    det_t sub [4][4];
    acc = '0;
    for (int c = 0; c < 5; c++) begin
      for (int r = 1; r < 5; r++) begin
        for (int k = 0; k < 4; k++) begin
          sub[r-1][k] = m[r][(k < c) ? k : k + 1];
        end
      end
      if (c % 2 == 0) acc = acc + m[0][c] * det4(sub);
      else            acc = acc - m[0][c] * det4(sub);
    end
    return acc;
  endfunction

  det_t m5 [N][N];

  // Unpack the row-major element vector and sign-extend every element.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        m5[i][j] = det_t'(elem_t'(matriz_5x5[(i*N+j)*ELEM_W +: ELEM_W]));
      end
    end
  end

  assign det = det5(m5);

endmodule

// File: rtl/controlador_det_5x5.sv
// Streams 25 signed elements into a matrix register, lets the combinational
// determinant settle for CALC_CYCLES cycles, then presents the registered
// result on a valid/ready output.
//
// Timing: matriz -> determinante_5x5 -> det_out is a CALC_CYCLES multicycle
// path (setup = CALC_CYCLES, hold = CALC_CYCLES-1). The matrix register is
// frozen in CALC and DONE, so only the final capture edge samples it.
module controlador_det_5x5
  import det_pkg::*;
#(
  parameter int CALC_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ELEM_W-1:0]       in_data,
  input  logic                    cancelar,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DET_W-1:0] det_out,
  output logic                    busy,
  output logic [15:0]             num_matrizes
);

  localparam logic [4:0] LAST_ELEM   = 5'(N * N - 1);
  localparam logic [3:0] LAST_SETTLE = 4'(CALC_CYCLES - 1);

  state_t           state;
  logic [4:0]       elem_cnt;
  logic [3:0]       settle_cnt;
  logic [MAT_W-1:0] matriz;
  logic [15:0]      num_cnt;
  det_t             det_calc;
  logic             accept;

  // Gating with rst keeps in_ready low for the whole reset pulse.
  assign in_ready     = !rst && (state == IDLE || state == LOAD);
  assign accept       = in_valid && in_ready;
  assign busy         = (state != IDLE);
  assign out_valid    = (state == DONE);
  assign num_matrizes = num_cnt;

  determinante_5x5 u_det (
    .matriz_5x5 (matriz),
    .det        (det_calc)
  );

  // Control FSM, element loading, settle counting and result capture.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      elem_cnt   <= '0;
      settle_cnt <= '0;
      // NOTE: the matrix register is cleared on reset so a result can never
      // be derived from a previous session's elements.
      matriz     <= '0;
      det_out    <= '0;
      num_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // cancelar has no effect here; the first element starts a load.
          if (accept) begin
            matriz[0 +: ELEM_W] <= in_data;
            elem_cnt            <= 5'd1;
            state               <= LOAD;
          end
        end
        LOAD: begin
          if (cancelar) begin
            state      <= IDLE;
            elem_cnt   <= '0;
            settle_cnt <= '0;
          end else if (accept) begin
            matriz[elem_cnt*ELEM_W +: ELEM_W] <= in_data;
            if (elem_cnt == LAST_ELEM) begin
              elem_cnt   <= '0;
              settle_cnt <= '0;
              state      <= CALC;
            end else begin
              elem_cnt <= elem_cnt + 5'd1;
            end
          end
        end
        CALC: begin
          if (cancelar) begin
            state      <= IDLE;
            elem_cnt   <= '0;
            settle_cnt <= '0;
          end else if (settle_cnt == LAST_SETTLE) begin
            det_out    <= det_calc;
            settle_cnt <= '0;
            state      <= DONE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        DONE: begin
          // A pending result is only released by the consumer handshake.
          if (out_ready) begin
            num_cnt <= num_cnt + 16'd1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_det_5x5.sv
// Directed bench for controlador_det_5x5: a table of matrices with
// hand-computed determinants, plus hand-written hold, gap, cancel, reset and
// counter-wrap sequences.
module tb_controlador_det_5x5;

  localparam int CALC_CYCLES = 2;

  typedef logic [24:0][7:0] mat_t;

  typedef struct {
    string       name;
    mat_t        m;
    logic [31:0] det;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        cancelar = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] det_out;
  logic        busy;
  logic [15:0] num_matrizes;

  int tests = 0;
  int fails = 0;

  controlador_det_5x5 #(.CALC_CYCLES(CALC_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .cancelar     (cancelar),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .det_out      (det_out),
    .busy         (busy),
    .num_matrizes (num_matrizes)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic mat_t diag(input logic [7:0] d, input logic [7:0] off);
    mat_t m;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        m[i*5+j] = (i == j) ? d : off;
    return m;
  endfunction

  // Feeds elements 0..count-1; optional random idle gaps between accepts.
  task automatic load(input mat_t m, input int count, input bit gaps);
    for (int k = 0; k < count; k++) begin
      @(negedge clk);
      if (gaps) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 1) == 0) break;
          in_valid = 1'b0;
          in_data  = 8'hA5;
          @(negedge clk);
          if (k > 0) check("busy_during_gap", 32'(busy), 32'd1);
        end
      end
      in_valid = 1'b1;
      in_data  = m[k];
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  // Counts edges from the last accept until out_valid rises.
  task automatic wait_result();
    int lat;
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid) break;
    end
    check("result_latency", 32'(lat), 32'(CALC_CYCLES));
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("hs_out_valid_low", 32'(out_valid), 32'd0);
    check("hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  vec_t vecs [8];
  mat_t m;
  logic [15:0] cnt;
  logic seen;

  initial begin
    // Build vector table.
    vecs[0] = '{"identity", diag(8'd1, 8'd0), 32'd1};
    m = '0;
    for (int i = 0; i < 5; i++)
      for (int j = i; j < 5; j++)
        m[i*5+j] = 8'(i + 1);
    vecs[1] = '{"upper_tri", m, 32'd120};
    m = diag(8'd2, 8'd1);
    for (int j = 0; j < 5; j++) m[15+j] = m[10+j];
    vecs[2] = '{"row3_eq_row2", m, 32'd0};
    vecs[3] = '{"neg_identity", diag(8'hFF, 8'd0), 32'hFFFF_FFFF};
    m = diag(8'd1, 8'd0);
    m[0] = 8'd0; m[1] = 8'd1; m[5] = 8'd1; m[6] = 8'd0;
    vecs[4] = '{"row_swap", m, 32'hFFFF_FFFF};
    vecs[5] = '{"i_plus_j", diag(8'd2, 8'd1), 32'd6};
    vecs[6] = '{"2i_plus_j", diag(8'd3, 8'd1), 32'd112};
    vecs[7] = '{"diag100_wrap", diag(8'd100, 8'd0), 32'h540B_E400};

    // Reset state.
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_det_out", det_out, 32'd0);
    check("rst_num", 32'(num_matrizes), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Table-driven vectors.
    for (int v = 0; v < 8; v++) begin
      load(vecs[v].m, 25, 1'b0);
      check({vecs[v].name, "_busy_calc"}, 32'(busy), 32'd1);
      wait_result();
      check({vecs[v].name, "_det"}, det_out, vecs[v].det);
      handshake();
      check({vecs[v].name, "_num"}, 32'(num_matrizes), 32'(v + 1));
    end
    cnt = 16'd8;

    // Result held under back-pressure; inputs ignored in DONE.
    load(vecs[2].m, 25, 1'b0);
    wait_result();
    m = vecs[1].m;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h7F;
      @(posedge clk);
      #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_det", det_out, 32'd0);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    handshake();
    cnt++;
    check("hold_num", 32'(num_matrizes), 32'(cnt));

    // Load with random in_valid gaps.
    load(vecs[1].m, 25, 1'b1);
    check("gap_busy_calc", 32'(busy), 32'd1);
    wait_result();
    check("gap_det", det_out, 32'd120);
    handshake();
    cnt++;

    // Cancel together with element 12, then a fresh identity load.
    load(vecs[4].m, 12, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h55;
    cancelar = 1'b1;
    @(posedge clk);
    #1;
    cancelar = 1'b0;
    in_valid = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_in_ready", 32'(in_ready), 32'd1);
    check("cancel_det_kept", det_out, 32'd120);
    load(vecs[0].m, 25, 1'b0);
    wait_result();
    check("after_cancel_det", det_out, 32'd1);
    handshake();
    cnt++;
    check("after_cancel_num", 32'(num_matrizes), 32'(cnt));

    // Cancel during CALC: no result, counter unchanged.
    load(vecs[5].m, 25, 1'b0);
    @(negedge clk);
    cancelar = 1'b1;
    @(posedge clk);
    #1 cancelar = 1'b0;
    check("calc_cancel_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1 seen = seen | out_valid;
    end
    check("calc_cancel_no_valid", 32'(seen), 32'd0);
    check("calc_cancel_det", det_out, 32'd1);
    check("calc_cancel_num", 32'(num_matrizes), 32'(cnt));

    // Cancel in DONE is ignored.
    load(vecs[6].m, 25, 1'b0);
    wait_result();
    @(negedge clk);
    cancelar = 1'b1;
    @(posedge clk);
    #1 cancelar = 1'b0;
    check("done_cancel_valid", 32'(out_valid), 32'd1);
    check("done_cancel_det", det_out, 32'd112);
    handshake();

    // Counter wrap from 0xFFFF to 0.
    @(negedge clk);
    force dut.num_cnt = 16'hFFFF;
    #1 release dut.num_cnt;
    check("wrap_preload", 32'(num_matrizes), 32'h0000_FFFF);
    load(vecs[0].m, 25, 1'b0);
    wait_result();
    handshake();
    check("wrap_num", 32'(num_matrizes), 32'd0);

    // Reset pulse mid-CALC.
    load(vecs[1].m, 25, 1'b0);
    wait_result();
    handshake();
    load(vecs[6].m, 25, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_det", det_out, 32'd0);
    check("midrst_num", 32'(num_matrizes), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_in_ready_after", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 2 * CALC_CYCLES + 4; c++) begin
      @(posedge clk);
      #1 seen = seen | out_valid;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);

    // Normal operation after reset.
    load(vecs[3].m, 25, 1'b0);
    wait_result();
    check("post_rst_det", det_out, 32'hFFFF_FFFF);
    handshake();
    check("post_rst_num", 32'(num_matrizes), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/controlador_det_5x5.md
CONTROLADOR_DET_5X5 -- requirements
Module: controlador_det_5x5

Interface
REQ-001 SHALL have parameter CALC_CYCLES, default 2, the number of settle cycles allowed for the combinational determinant datapath (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data holds a valid matrix element.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts an element this cycle.
REQ-006 SHALL have port in_data, input, 8 bits: signed element, row-major order (k = i*5+j).
REQ-007 SHALL have port cancelar, input, 1 bit: synchronous abort of the current load or calculation.
REQ-008 SHALL have port out_valid, output, 1 bit: det_out holds a valid result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port det_out, output, 32 bits: registered signed determinant.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port num_matrizes, output, 16 bits: count of results accepted by the consumer.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, CALC and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and LOAD; an element is accepted on an edge where in_valid&&in_ready.
REQ-015 SHALL write accepted element k into matrix register bits [k*8 +: 8], which equals [(i*40+j*8) +: 8], using a 5-bit element counter 0..24.
REQ-016 SHALL transition: IDLE->LOAD on the first accept (k=0); LOAD->CALC on the accept of k=24; counter cleared on entering CALC.
REQ-017 SHALL hold the matrix register stable during CALC and DONE; in_data is ignored there.
REQ-018 SHALL stay in CALC for exactly CALC_CYCLES cycles, then capture the datapath output into det_out and enter DONE; out_valid rises CALC_CYCLES edges after the k=24 accept edge.
REQ-019 SHALL keep out_valid=1 and det_out stable in DONE until out_valid&&out_ready, then go to IDLE with out_valid=0 on the following cycle.
REQ-020 SHALL increment num_matrizes by 1 on each DONE handshake; it wraps 0xFFFF->0x0000.
REQ-021 SHALL, on cancelar=1 in LOAD or CALC, return to IDLE, clear the element and settle counters, and leave det_out and num_matrizes unchanged.
REQ-022 SHALL give cancelar priority over a simultaneous element accept; that element is dropped.
REQ-023 SHALL ignore cancelar in IDLE and DONE; a pending result is never discarded.
REQ-024 SHALL hold in_ready=0 in DONE, so no back-to-back overlap occurs; the next matrix may start the cycle after returning to IDLE.
REQ-025 SHALL treat det_out as the 32-bit two's-complement result of the datapath, with no saturation or overflow flag.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-LOAD or mid-CALC, force state IDLE, both counters 0, matrix register 0, det_out 0, out_valid 0 and num_matrizes 0.
REQ-027 SHALL, while in reset, drive in_ready=0 and busy=0; in_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-028 SHALL take from shared package det_pkg: N=5, ELEM_W=8, MAT_W=200, DET_W=32 and the FSM state enum.
REQ-029 SHALL instantiate exactly one determinante_5x5 sub-module (ports matriz_5x5, det), fed from the matrix register.
REQ-030 SHALL treat the path from the matrix register to det_out as a CALC_CYCLES multicycle path, documented in the constraints.

Verification
REQ-031 SHALL cover: load a 5x5 identity, out_ready=1 -> det_out=1, out_valid exactly CALC_CYCLES edges after the 25th accept, num_matrizes=1.
REQ-032 SHALL cover: upper-triangular matrix with row i holding value i+1 for j>=i -> det_out=120.
REQ-033 SHALL cover: diagonal 2, off-diagonal 1, row 3 copied from row 2 -> det_out=0; then hold out_ready=0 for 10 cycles -> out_valid and det_out stable, in_ready=0.
REQ-034 SHALL cover: in_valid toggled randomly during the load -> same result as a gap-free load; busy=1 from the first accept until the handshake.
REQ-035 SHALL cover: cancelar asserted together with element k=12 -> IDLE next cycle, element dropped; a fresh identity load then yields det_out=1.
REQ-036 SHALL cover: rst pulsed mid-CALC -> all outputs reset immediately, with no out_valid afterwards; num_matrizes wrap from 0xFFFF to 0 (forced via preload or a long run).
